pattern_detect_ctrl: RTL

Programmable serial pattern-detection controller that configures, arms, runs and stops a bit-serial sequence matcher. It generalises the fixed Moore-style 1010 detectors to a runtime-loaded pattern of up to MAX_LEN bits, with selectable overlapping or non-overlapping matching, a match counter and an optional stop-after-N-matches limit. It sits between a config/control master (CPU-side registers or a test sequencer) and a qualified serial bit stream.

---
 rtl/pattern_detect_pkg.sv | 16 +
 rtl/pattern_detect_ctrl_window.sv | 49 ++++
 rtl/pattern_detect_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pattern_detect_pkg.sv
// Shared types and reset-default configuration for the programmable pattern detector.
// The defaults make an unconfigured detector behave as a classic non-overlapping 1010 matcher.
package pattern_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEF_PATTERN = 32'b1010;
    localparam int          DEF_LEN     = 4;
    localparam logic        DEF_OVERLAP = 1'b0;
    localparam int          DEF_LIMIT   = 0;

endpackage

// File: rtl/pattern_detect_ctrl_window.sv
// Bit-serial history window with fill tracking and a length-masked pattern compare.
// hit is combinational and describes the window as it will look after this cycle's shift.
module pattern_window #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift,
    input  logic               clear,
    input  logic               clear_fill,
    input  logic               din,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    // The newest bit is tapped straight from din, so only the older MAX_LEN-1 bits are stored.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_fill_next;

    assign w_hist_next = {r_hist, din};
    assign w_fill_next = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(len));
        end
    end

    assign hit = shift && (w_fill_next >= len) && (((w_hist_next ^ pattern) & w_mask) == '0);

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values;
    // the history is a handful of flops, so it is reset together with fill rather than left unknown.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (shift) begin
            r_hist <= w_hist_next[MAX_LEN-2:0];
            r_fill <= clear_fill ? '0 : w_fill_next;
        end
    end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Control layer of the pattern detector: config registers, IDLE/RUN/DONE FSM,
// saturating match counter and stop-after-N limit around the pattern_window datapath.
module pattern_detect_ctrl
    import pattern_detect_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_limit,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               din,
    input  logic               din_valid,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);

    state_t             r_state, w_state_next;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_limit;
    logic               r_cfg_ready, r_cfg_err, r_match, r_busy, r_done;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               w_cfg_wr, w_len_ok, w_restart, w_shift, w_hit, w_limit_hit;

    assign w_cfg_wr    = cfg_valid && r_cfg_ready;
    assign w_len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    // abort outranks start everywhere, and a restart discards the din of that cycle.
    assign w_restart   = start && !abort;
    assign w_shift     = (r_state == ST_RUN) && din_valid && !start && !abort;
    assign w_cnt_next  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_limit_hit = w_hit && (r_limit != '0) && (w_cnt_next == r_limit);

    pattern_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk        (clk),
        .rst        (rst),
        .shift      (w_shift),
        .clear      (w_restart),
        .clear_fill (w_hit && !r_overlap),
        .din        (din),
        .pattern    (r_pattern),
        .len        (r_len),
        .hit        (w_hit)
    );

    // NOTE: the next state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_restart) w_state_next = ST_RUN;
            ST_RUN: begin
                if (abort)            w_state_next = ST_IDLE;
                else if (w_limit_hit) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (abort)      w_state_next = ST_IDLE;
                else if (start) w_state_next = ST_RUN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pattern   <= MAX_LEN'(DEF_PATTERN);
            r_len       <= LEN_W'(DEF_LEN);
            r_overlap   <= DEF_OVERLAP;
            r_limit     <= CNT_W'(DEF_LIMIT);
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
            r_match     <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cfg_ready <= (w_state_next == ST_IDLE);
            r_busy      <= (w_state_next == ST_RUN);
            r_done      <= (w_state_next == ST_DONE);
            r_cfg_err   <= w_cfg_wr && !w_len_ok;
            r_match     <= w_hit;
            if (w_cfg_wr && w_len_ok) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_limit   <= cfg_limit;
            end
            if (w_restart) begin
                r_cnt <= '0;
            end else if (w_hit) begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
